// File: rtl/token_rx_collector.sv
// token_rx_collector: assembles 3-byte USB token packets {PID, byte1, byte2} from the PHY byte stream.
// Optional inter-byte idle timeout is compiled in with TOKEN_RX_TIMEOUT_EN.
module token_rx_collector #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_sop,
  input  logic        rx_eop,
  input  logic        rx_abort,
  output logic [23:0] token_data,
  output logic        token_valid,
  output logic        pid_err,
  output logic        len_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, GOT_PID, GOT_B1, DROP} state_t;
  state_t state, state_n;
  logic [7:0] pid_q, b1_q;
  logic pid_ok, is_tok, in_pkt, tmo, tv_n, pe_n, le_n;
  always_comb begin
    pid_ok = rx_byte[7:4] == ~rx_byte[3:0];
    is_tok = rx_byte == 8'h1E || rx_byte == 8'h96 || rx_byte == 8'hD2;
    in_pkt = state == GOT_PID || state == GOT_B1;
    state_n = state;
    tv_n = 1'b0;
    pe_n = 1'b0;
    le_n = 1'b0;
    if (rx_abort)
      state_n = IDLE;
    else if (rx_valid && rx_sop) begin
      // a new SOP interrupts any partial token, then is handled as a fresh start
      pe_n = !pid_ok;
      le_n = in_pkt || (pid_ok && is_tok && rx_eop);
      state_n = rx_eop ? IDLE : (pid_ok && is_tok) ? GOT_PID : DROP;
    end else if (rx_valid) begin
      case (state)
        GOT_PID: begin
          le_n = rx_eop;
          state_n = rx_eop ? IDLE : GOT_B1;
        end
        GOT_B1: begin
          tv_n = rx_eop;
          le_n = !rx_eop;
          state_n = rx_eop ? IDLE : DROP;
        end
        DROP: state_n = rx_eop ? IDLE : DROP;
        default: state_n = IDLE;
      endcase
    end else if (tmo) begin
      le_n = in_pkt;
      state_n = IDLE;
    end
  end
`ifdef TOKEN_RX_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = state != IDLE && cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) cnt <= '0;
    else cnt <= (rx_abort || rx_valid || state == IDLE || tmo) ? '0 : cnt + 8'd1;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      pid_q <= '0;
      b1_q <= '0;
      token_data <= '0;
      token_valid <= 1'b0;
      pid_err <= 1'b0;
      len_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      token_valid <= tv_n;
      pid_err <= pe_n;
      len_err <= le_n;
      busy <= state_n != IDLE;
      if (!rx_abort && rx_valid && rx_sop) pid_q <= rx_byte;
      if (!rx_abort && rx_valid && !rx_sop && state == GOT_PID) b1_q <= rx_byte;
      if (tv_n) token_data <= {pid_q, b1_q, rx_byte};
    end
  end
endmodule
